i2c_seq: RTL and testbench
==========================

I2C_SEQ -- requirements
Module: i2c_seq

Interface
REQ-001 SHALL provide parameter CLK_DIV, default 250, clk cycles per i2c_strobe pulse (legal range 4..65535).
REQ-002 SHALL provide parameter N_CMDS, default 16, command-table depth (power of two, 2..32).
REQ-003 SHALL provide parameter MAX_RETRY, default 3, NACK retries per command.
REQ-004 clk  in  1  clock.
REQ-005 arst_n  in  1  reset, asynchronous, active-low.
REQ-006 cmd_we / cmd_idx / cmd_wdata  in  1 / log2(N_CMDS) / 18  table write; cmd_wdata = {last, rdwr, reg_addr[7:0], wrdata[7:0]}.
REQ-007 dev_addr  in  7  target I2C address, sampled at start.
REQ-008 start  in  1  single-cycle pulse; begins the sequence at entry 0.
REQ-009 busy / done / error  out  1 each  status; done and error are one-cycle pulses.
REQ-010 rd_valid / rd_idx / rd_data  out  1 / log2(N_CMDS) / 8  read result; rd_valid is a one-cycle pulse.
REQ-011 i2c_strobe, i2c_enable, i2c_addr[6:0], reg_rdwr, reg_addr[7:0], reg_len[4:0], reg_wrdata[7:0]  out  controller drive.
REQ-012 reg_done, i2c_ack, i2c_read_done, reg_rddata[7:0]  in  controller status; i2c_ack=1 means NACK.

Function
REQ-013 Strobe divider SHALL pulse i2c_strobe for 1 clk every CLK_DIV clks, free-running from reset.
REQ-014 FSM states: IDLE, LOAD, ISSUE, WAIT, CHECK, NEXT; busy=1 in every state except IDLE.
REQ-015 IDLE->LOAD on start; idx cleared; dev_addr latched to i2c_addr; start ignored when busy.
REQ-016 LOAD SHALL register table[idx] onto reg_rdwr/reg_addr/reg_wrdata, set reg_len=3 for write or 2 for read, then go to ISSUE.
REQ-017 ISSUE SHALL hold i2c_enable=1 until the clk after the next i2c_strobe pulse, then drop it and enter WAIT.
REQ-018 WAIT SHALL advance to CHECK on the first clk where reg_done=1 and i2c_enable=0.
REQ-019 CHECK with i2c_ack=0: for a read, rd_valid=1 with rd_idx=idx and rd_data=reg_rddata; then NEXT.
REQ-020 CHECK with i2c_ack=1: handled per REQ-027/REQ-028.
REQ-021 NEXT: if the entry had last=1 or idx=N_CMDS-1, pulse done and go IDLE; otherwise idx+1, go LOAD.
REQ-022 ISSUE SHALL NOT re-assert i2c_enable while reg_done from the previous command is still 1, which prevents a double launch.
REQ-023 cmd_we SHALL write the table in any state; a write to the entry currently in LOAD takes effect on the next LOAD.
REQ-024 Read-issue latency from start to first i2c_enable SHALL be 2 clks.

Reset
REQ-025 On arst_n=0: state IDLE; busy, done, error, rd_valid, i2c_enable, i2c_strobe = 0; divider, idx and retry count = 0; reg_* outputs and i2c_addr = 0.
REQ-026 Table contents SHALL NOT be reset; reset mid-transaction SHALL drop i2c_enable within the same cycle (asynchronous).

Configuration
REQ-027 With I2C_SEQ_RETRY_EN defined: on NACK, if retry count < MAX_RETRY, increment it and go to LOAD with the same idx; otherwise pulse error and go IDLE. Retry count clears on each NEXT.
REQ-028 Without I2C_SEQ_RETRY_EN: any NACK SHALL immediately pulse error and return to IDLE; MAX_RETRY is unused.

Structure
REQ-029 Package i2c_seq_pkg SHALL hold the FSM state enum, the command-entry field offsets, and constants REG_LEN_WR=3 and REG_LEN_RD=2.
REQ-030 Sub-module i2c_strobe_gen (the CLK_DIV divider) SHALL be used; the table SHALL be a plain register array inside i2c_seq.

Verification
REQ-031 CLK_DIV=4, idle 40 clks -> exactly 10 i2c_strobe pulses, each 1 clk wide.
REQ-032 Table {0:W 0x10=0xA5}, {1:W 0x11=0x5A last}, ack model 0, start -> two transactions, reg_len=3 each, done pulse once, error=0.
REQ-033 Table {0:R 0x75 last}, model returns 0x68 -> rd_valid once with rd_idx=0, rd_data=0x68; reg_len=2.
REQ-034 RETRY_EN, MAX_RETRY=3, model NACKs entry 0 twice then ACKs -> 3 launches of entry 0, then done, no error; constant NACK -> 4 launches, then error.
REQ-035 Without RETRY_EN, NACK on entry 2 of 4 -> error pulse, entry 3 never launched, busy=0.
REQ-036 arst_n low during WAIT -> i2c_enable=0 and busy=0 immediately; new start after release runs from entry 0.

Source files
------------

// File: rtl/i2c_seq_pkg.sv
// Shared types and constants for the I2C command sequencer: FSM states,
// command-entry field layout and controller transfer lengths.
package i2c_seq_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_ISSUE,
        ST_WAIT,
        ST_CHECK,
        ST_NEXT
    } state_e;

    // Command entry layout: {last, rdwr, reg_addr[7:0], wrdata[7:0]}
    localparam int CMD_W        = 18;
    localparam int CMD_LAST_BIT = 17;
    localparam int CMD_RDWR_BIT = 16;
    localparam int CMD_ADDR_LSB = 8;
    localparam int CMD_DATA_LSB = 0;

    localparam logic [4:0] REG_LEN_WR = 5'd3;
    localparam logic [4:0] REG_LEN_RD = 5'd2;

    function automatic logic [4:0] reg_len_for(input logic rdwr);
        return rdwr ? REG_LEN_RD : REG_LEN_WR;
    endfunction

endpackage

// File: rtl/i2c_strobe_gen.sv
// Free-running divider: one-clk strobe every CLK_DIV clks, counting from reset.
module i2c_strobe_gen #(
    parameter int CLK_DIV = 250
) (
    input  logic clk,
    input  logic arst_n,
    output logic strobe
);

    logic [15:0] cnt_q, cnt_d;
    logic        strobe_q, strobe_d;

    always_comb begin
        strobe_d = (cnt_q == 16'(CLK_DIV - 1));
        cnt_d    = strobe_d ? 16'd0 : cnt_q + 16'd1;
    end

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            cnt_q    <= 16'd0;
            strobe_q <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            strobe_q <= strobe_d;
        end
    end

    assign strobe = strobe_q;

endmodule

// File: rtl/i2c_seq.sv
// I2C command sequencer: walks a register-table of write/read commands and
// drives an external I2C register controller. Define I2C_SEQ_RETRY_EN to
// retry NACKed commands up to MAX_RETRY times instead of aborting.
module i2c_seq
    import i2c_seq_pkg::*;
#(
    parameter int CLK_DIV   = 250,
    parameter int N_CMDS    = 16,
    parameter int MAX_RETRY = 3,
    localparam int IDX_W    = $clog2(N_CMDS)
) (
    input  logic             clk,
    input  logic             arst_n,
    input  logic             cmd_we,
    input  logic [IDX_W-1:0] cmd_idx,
    input  logic [17:0]      cmd_wdata,
    input  logic [6:0]       dev_addr,
    input  logic             start,
    output logic             busy,
    output logic             done,
    output logic             error,
    output logic             rd_valid,
    output logic [IDX_W-1:0] rd_idx,
    output logic [7:0]       rd_data,
    output logic             i2c_strobe,
    output logic             i2c_enable,
    output logic [6:0]       i2c_addr,
    output logic             reg_rdwr,
    output logic [7:0]       reg_addr,
    output logic [4:0]       reg_len,
    output logic [7:0]       reg_wrdata,
    input  logic             reg_done,
    input  logic             i2c_ack,
    input  logic             i2c_read_done,
    input  logic [7:0]       reg_rddata,
    output state_e           dbg_state
);

    logic [CMD_W-1:0] table_q [N_CMDS];
    logic [CMD_W-1:0] entry;

    state_e           state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d, rd_idx_q, rd_idx_d;
    logic [7:0]       retry_q, retry_d, rd_data_q, rd_data_d;
    logic [7:0]       reg_addr_q, reg_addr_d, reg_wrdata_q, reg_wrdata_d;
    logic [6:0]       i2c_addr_q, i2c_addr_d;
    logic [4:0]       reg_len_q, reg_len_d;
    logic             last_q, last_d, reg_rdwr_q, reg_rdwr_d, en_q, en_d;
    logic             busy_q, busy_d, done_q, done_d, error_q, error_d;
    logic             rd_valid_q, rd_valid_d;

    i2c_strobe_gen #(.CLK_DIV(CLK_DIV)) u_strobe (
        .clk    (clk),
        .arst_n (arst_n),
        .strobe (i2c_strobe)
    );

    // Table is deliberately unreset so a reset does not wipe the program.
    always_ff @(posedge clk) begin
        if (cmd_we) table_q[cmd_idx] <= cmd_wdata;
    end

    assign entry = table_q[idx_q];

    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        retry_d      = retry_q;
        last_d       = last_q;
        i2c_addr_d   = i2c_addr_q;
        reg_rdwr_d   = reg_rdwr_q;
        reg_addr_d   = reg_addr_q;
        reg_wrdata_d = reg_wrdata_q;
        reg_len_d    = reg_len_q;
        en_d         = en_q;
        rd_idx_d     = rd_idx_q;
        rd_data_d    = rd_data_q;
        done_d       = 1'b0;
        error_d      = 1'b0;
        rd_valid_d   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    idx_d      = '0;
                    retry_d    = 8'd0;
                    i2c_addr_d = dev_addr;
                    state_d    = ST_LOAD;
                end
            end
            ST_LOAD: begin
                reg_rdwr_d   = entry[CMD_RDWR_BIT];
                reg_addr_d   = entry[CMD_ADDR_LSB +: 8];
                reg_wrdata_d = entry[CMD_DATA_LSB +: 8];
                reg_len_d    = reg_len_for(entry[CMD_RDWR_BIT]);
                last_d       = entry[CMD_LAST_BIT];
                en_d         = !reg_done;
                state_d      = ST_ISSUE;
            end
            ST_ISSUE: begin
                // A lingering reg_done from the previous command must clear
                // before launching, or the controller could fire twice.
                if (!en_q) begin
                    en_d = !reg_done;
                end else if (i2c_strobe) begin
                    en_d    = 1'b0;
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (reg_done && !en_q) state_d = ST_CHECK;
            end
            ST_CHECK: begin
                if (!i2c_ack) begin
                    if (reg_rdwr_q) begin
                        rd_valid_d = 1'b1;
                        rd_idx_d   = idx_q;
                        rd_data_d  = reg_rddata;
                    end
                    state_d = ST_NEXT;
                end else begin
`ifdef I2C_SEQ_RETRY_EN
                    if (retry_q < 8'(MAX_RETRY)) begin
                        retry_d = retry_q + 8'd1;
                        state_d = ST_LOAD;
                    end else begin
                        error_d = 1'b1;
                        state_d = ST_IDLE;
                    end
`else
                    error_d = 1'b1;
                    state_d = ST_IDLE;
`endif
                end
            end
            ST_NEXT: begin
                retry_d = 8'd0;
                if (last_q || idx_q == IDX_W'(N_CMDS - 1)) begin
                    done_d  = 1'b1;
                    state_d = ST_IDLE;
                end else begin
                    idx_d   = idx_q + 1'b1;
                    state_d = ST_LOAD;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            state_q      <= ST_IDLE;
            idx_q        <= '0;
            retry_q      <= 8'd0;
            last_q       <= 1'b0;
            i2c_addr_q   <= 7'd0;
            reg_rdwr_q   <= 1'b0;
            reg_addr_q   <= 8'd0;
            reg_wrdata_q <= 8'd0;
            reg_len_q    <= 5'd0;
            en_q         <= 1'b0;
            rd_idx_q     <= '0;
            rd_data_q    <= 8'd0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            error_q      <= 1'b0;
            rd_valid_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            retry_q      <= retry_d;
            last_q       <= last_d;
            i2c_addr_q   <= i2c_addr_d;
            reg_rdwr_q   <= reg_rdwr_d;
            reg_addr_q   <= reg_addr_d;
            reg_wrdata_q <= reg_wrdata_d;
            reg_len_q    <= reg_len_d;
            en_q         <= en_d;
            rd_idx_q     <= rd_idx_d;
            rd_data_q    <= rd_data_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            error_q      <= error_d;
            rd_valid_q   <= rd_valid_d;
        end
    end

    assign busy       = busy_q;
    assign done       = done_q;
    assign error      = error_q;
    assign rd_valid   = rd_valid_q;
    assign rd_idx     = rd_idx_q;
    assign rd_data    = rd_data_q;
    assign i2c_enable = en_q;
    assign i2c_addr   = i2c_addr_q;
    assign reg_rdwr   = reg_rdwr_q;
    assign reg_addr   = reg_addr_q;
    assign reg_len    = reg_len_q;
    assign reg_wrdata = reg_wrdata_q;
    assign dbg_state  = state_q;

endmodule

// File: tb/tb_i2c_seq.sv
// Bench for i2c_seq: controller model plus an event scoreboard (launch, read
// result, done, error). Covers retry behaviour when I2C_SEQ_RETRY_EN is defined.
module tb_i2c_seq;
    import i2c_seq_pkg::*;

    localparam int N = 4;

    logic        clk = 1'b0;
    logic        arst_n = 1'b0;
    logic        cmd_we = 1'b0;
    logic [1:0]  cmd_idx = '0;
    logic [17:0] cmd_wdata = '0;
    logic [6:0]  dev_addr = '0;
    logic        start = 1'b0;
    logic        busy, done, error, rd_valid;
    logic [1:0]  rd_idx;
    logic [7:0]  rd_data;
    logic        i2c_strobe, i2c_enable, reg_rdwr;
    logic [6:0]  i2c_addr;
    logic [7:0]  reg_addr, reg_wrdata;
    logic [4:0]  reg_len;
    logic        reg_done = 1'b0, i2c_ack = 1'b0, i2c_read_done = 1'b0;
    logic [7:0]  reg_rddata = '0;
    state_e      dbg_state;

    int tests = 0;
    int fails = 0;
    logic [31:0] exp_q[$];
    logic        ack_q[$];

    i2c_seq #(.CLK_DIV(4), .N_CMDS(N), .MAX_RETRY(3)) dut (
        .clk(clk), .arst_n(arst_n), .cmd_we(cmd_we), .cmd_idx(cmd_idx),
        .cmd_wdata(cmd_wdata), .dev_addr(dev_addr), .start(start),
        .busy(busy), .done(done), .error(error), .rd_valid(rd_valid),
        .rd_idx(rd_idx), .rd_data(rd_data), .i2c_strobe(i2c_strobe),
        .i2c_enable(i2c_enable), .i2c_addr(i2c_addr), .reg_rdwr(reg_rdwr),
        .reg_addr(reg_addr), .reg_len(reg_len), .reg_wrdata(reg_wrdata),
        .reg_done(reg_done), .i2c_ack(i2c_ack), .i2c_read_done(i2c_read_done),
        .reg_rddata(reg_rddata), .dbg_state(dbg_state)
    );

    // clock / reset
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] ev_launch(input logic [6:0] dev, input logic rdwr,
                                              input logic [7:0] a, input logic [7:0] d);
        return {3'd1, dev, rdwr, (rdwr ? 5'd2 : 5'd3), a, d};
    endfunction
    function automatic logic [31:0] ev_rd(input logic [7:0] idx, input logic [7:0] d);
        return {3'd2, 13'd0, idx, d};
    endfunction
    localparam logic [31:0] EV_DONE = {3'd3, 29'd0};
    localparam logic [31:0] EV_ERR  = {3'd4, 29'd0};

    // controller model: reg_done held 5 clks, read data = reg_addr ^ 0x1D
    initial begin
        logic [7:0] a;
        logic       nack;
        int         n;
        forever begin
            @(negedge clk);
            if (arst_n && i2c_enable) begin
                a    = reg_addr;
                nack = (ack_q.size() > 0) ? ack_q.pop_front() : 1'b0;
                n    = 0;
                while (i2c_enable && n < 200) begin
                    @(negedge clk);
                    n++;
                end
                repeat (2) @(negedge clk);
                reg_done   = 1'b1;
                i2c_ack    = nack;
                reg_rddata = a ^ 8'h1D;
                repeat (5) @(negedge clk);
                reg_done = 1'b0;
            end
        end
    end

    // monitor
    task automatic sb_pop(input string name, input logic [31:0] act);
        if (exp_q.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL %s: unexpected event %0h, nothing expected", name, act);
        end else begin
            check(name, act, exp_q.pop_front());
        end
    endtask

    initial begin
        logic en_prev;
        en_prev = 1'b0;
        forever begin
            @(negedge clk);
            if (!arst_n) begin
                en_prev = 1'b0;
            end else begin
                if (i2c_enable && !en_prev)
                    sb_pop("launch", {3'd1, i2c_addr, reg_rdwr, reg_len, reg_addr, reg_wrdata});
                if (rd_valid) sb_pop("rd", {3'd2, 13'd0, 6'd0, rd_idx, rd_data});
                if (done)     sb_pop("done", EV_DONE);
                if (error)    sb_pop("error", EV_ERR);
                en_prev = i2c_enable;
            end
        end
    end

    // driver tasks
    task automatic write_cmd(input int idx, input logic last, input logic rdwr,
                             input logic [7:0] a, input logic [7:0] d);
        @(negedge clk);
        cmd_we    = 1'b1;
        cmd_idx   = 2'(idx);
        cmd_wdata = {last, rdwr, a, d};
        @(negedge clk);
        cmd_we = 1'b0;
    endtask

    task automatic pulse_start(input logic [6:0] dev, output int lat);
        @(negedge clk);
        dev_addr = dev;
        start    = 1'b1;
        lat      = 0;
        do begin
            @(negedge clk);
            start    = 1'b0;
            dev_addr = ~dev;
            lat++;
        end while (!i2c_enable && lat < 50);
    endtask

    task automatic run_seq(input string name, input logic [6:0] dev);
        int lat;
        int n;
        pulse_start(dev, lat);
        check({name, "_latency"}, 32'(lat), 32'd2);
        n = 0;
        while (busy && n < 3000) begin
            @(negedge clk);
            n++;
        end
        check({name, "_timeout"}, 32'(n < 3000), 32'd1);
        repeat (10) @(negedge clk);
        check({name, "_busy"}, 32'(busy), 32'd0);
        check({name, "_pending"}, 32'(exp_q.size()), 32'd0);
        exp_q.delete();
    endtask

    initial begin
        int strobes;
        int max_run;
        int run;
        int lat;
        int n;
        #12;
        check("rst_busy",   32'(busy), 32'd0);
        check("rst_enable", 32'(i2c_enable), 32'd0);
        check("rst_regs",   {3'd0, i2c_addr, reg_rdwr, reg_len, reg_addr, reg_wrdata}, 32'd0);
        check("rst_state",  32'(dbg_state), 32'(ST_IDLE));
        arst_n = 1'b1;

        // strobe divider: 40 clks -> 10 single-clk pulses
        strobes = 0;
        max_run = 0;
        run     = 0;
        repeat (40) begin
            @(negedge clk);
            if (i2c_strobe) begin
                strobes++;
                run++;
                if (run > max_run) max_run = run;
            end else begin
                run = 0;
            end
        end
        check("strobe_count", 32'(strobes), 32'd10);
        check("strobe_width", 32'(max_run), 32'd1);

        // two writes, second marked last
        write_cmd(0, 1'b0, 1'b0, 8'h10, 8'hA5);
        write_cmd(1, 1'b1, 1'b0, 8'h11, 8'h5A);
        exp_q.push_back(ev_launch(7'h3C, 1'b0, 8'h10, 8'hA5));
        exp_q.push_back(ev_launch(7'h3C, 1'b0, 8'h11, 8'h5A));
        exp_q.push_back(EV_DONE);
        run_seq("wr2", 7'h3C);

        // single read
        write_cmd(0, 1'b1, 1'b1, 8'h75, 8'h00);
        exp_q.push_back(ev_launch(7'h50, 1'b1, 8'h75, 8'h00));
        exp_q.push_back(ev_rd(8'd0, 8'h68));
        exp_q.push_back(EV_DONE);
        run_seq("rd1", 7'h50);

        // full table, no last flag: ends at last index
        write_cmd(0, 1'b0, 1'b0, 8'h20, 8'h01);
        write_cmd(1, 1'b0, 1'b1, 8'h30, 8'h00);
        write_cmd(2, 1'b0, 1'b1, 8'h41, 8'h00);
        write_cmd(3, 1'b0, 1'b0, 8'h50, 8'hFF);
        exp_q.push_back(ev_launch(7'h7F, 1'b0, 8'h20, 8'h01));
        exp_q.push_back(ev_launch(7'h7F, 1'b1, 8'h30, 8'h00));
        exp_q.push_back(ev_rd(8'd1, 8'h2D));
        exp_q.push_back(ev_launch(7'h7F, 1'b1, 8'h41, 8'h00));
        exp_q.push_back(ev_rd(8'd2, 8'h5C));
        exp_q.push_back(ev_launch(7'h7F, 1'b0, 8'h50, 8'hFF));
        exp_q.push_back(EV_DONE);
        run_seq("full4", 7'h7F);

        // NACK on entry 2: entry 3 must never launch
        ack_q = '{1'b0, 1'b0};
        exp_q.push_back(ev_launch(7'h01, 1'b0, 8'h20, 8'h01));
        exp_q.push_back(ev_launch(7'h01, 1'b1, 8'h30, 8'h00));
        exp_q.push_back(ev_rd(8'd1, 8'h2D));
`ifdef I2C_SEQ_RETRY_EN
        repeat (4) begin
            ack_q.push_back(1'b1);
            exp_q.push_back(ev_launch(7'h01, 1'b1, 8'h41, 8'h00));
        end
`else
        ack_q.push_back(1'b1);
        exp_q.push_back(ev_launch(7'h01, 1'b1, 8'h41, 8'h00));
`endif
        exp_q.push_back(EV_ERR);
        run_seq("nack2", 7'h01);
        check("nack2_acks_used", 32'(ack_q.size()), 32'd0);

`ifdef I2C_SEQ_RETRY_EN
        // two NACKs then ACK: three launches of entry 0, then done
        write_cmd(0, 1'b1, 1'b0, 8'h10, 8'hA5);
        ack_q = '{1'b1, 1'b1, 1'b0};
        repeat (3) exp_q.push_back(ev_launch(7'h22, 1'b0, 8'h10, 8'hA5));
        exp_q.push_back(EV_DONE);
        run_seq("retry_ok", 7'h22);
`endif

        // reset during ISSUE and during WAIT
        write_cmd(0, 1'b0, 1'b0, 8'h66, 8'h99);
        write_cmd(1, 1'b1, 1'b1, 8'h77, 8'h00);
        exp_q.push_back(ev_launch(7'h11, 1'b0, 8'h66, 8'h99));
        pulse_start(7'h11, lat);
        #2 arst_n = 1'b0;
        #1;
        check("rst_issue_enable", 32'(i2c_enable), 32'd0);
        check("rst_issue_busy",   32'(busy), 32'd0);
        exp_q.delete();
        repeat (2) @(negedge clk);
        arst_n = 1'b1;
        repeat (20) @(negedge clk);

        exp_q.push_back(ev_launch(7'h12, 1'b0, 8'h66, 8'h99));
        pulse_start(7'h12, lat);
        n = 0;
        while (i2c_enable && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("rst_wait_state", 32'(dbg_state), 32'(ST_WAIT));
        #2 arst_n = 1'b0;
        #1;
        check("rst_wait_enable", 32'(i2c_enable), 32'd0);
        check("rst_wait_busy",   32'(busy), 32'd0);
        check("rst_wait_len",    32'(reg_len), 32'd0);
        exp_q.delete();
        repeat (2) @(negedge clk);
        arst_n = 1'b1;
        repeat (20) @(negedge clk);

        exp_q.push_back(ev_launch(7'h13, 1'b0, 8'h66, 8'h99));
        exp_q.push_back(ev_launch(7'h13, 1'b1, 8'h77, 8'h00));
        exp_q.push_back(ev_rd(8'd1, 8'h6A));
        exp_q.push_back(EV_DONE);
        run_seq("after_rst", 7'h13);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
